// File: rtl/jogo_pkg.sv
// jogo_pkg: shared state encodings and default display timings for the memory game
package jogo_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'h0,
    ENDERECA = 4'h1,
    ACENDE   = 4'h2,
    APAGA    = 4'h3,
    PISCA    = 4'h4,
    FIM      = 4'hF
  } estado_t;
  localparam int ON_CYCLES_PADRAO  = 500;
  localparam int OFF_CYCLES_PADRAO = 250;
endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// contador_tempo: loadable up-counter with clear and terminal-count flag at LIMITE
module contador_tempo #(
  parameter int W      = 4,
  parameter int LIMITE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] valor,
  output logic [W-1:0] contagem,
  output logic         fim
);
  // clear wins over load, load wins over counting
  always_ff @(posedge clk)
    if (rst || clr) contagem <= '0;
    else contagem <= load ? valor : contagem + 1'b1;
  assign fim = contagem == W'(LIMITE);
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: shows stored plays 0..rodada on the LEDs; EXIBE_PISCA_FIM_EN adds an all-on flash before pronto
module exibe_sequencia
  import jogo_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_PADRAO,
  parameter int OFF_CYCLES = OFF_CYCLES_PADRAO,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);
  localparam int MAX_C  = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);
  localparam int LIMITE = MAX_C - 1;
  // the single counter always terminates at LIMITE, so each phase preloads its offset
  localparam logic [TW-1:0] CARGA_ON  = TW'(LIMITE - ON_CYCLES + 1);
  localparam logic [TW-1:0] CARGA_OFF = TW'(LIMITE - OFF_CYCLES + 1);
  estado_t           estado;
  logic [ADDR_W-1:0] rodada_reg;
  logic [TW-1:0]     contagem;
  logic              tc, carga, ultimo;
  assign ultimo    = mem_endereco == rodada_reg;
  assign ocupado   = estado != IDLE;
  assign db_estado = estado;
`ifdef EXIBE_PISCA_FIM_EN
  assign carga = estado == ENDERECA || (estado == ACENDE && tc) || (estado == APAGA && tc && ultimo);
`else
  assign carga = estado == ENDERECA || (estado == ACENDE && tc);
`endif
  contador_tempo #(.W(TW), .LIMITE(LIMITE)) u_tempo (
    .clk(clock),
    .rst(reset),
    .clr(estado == IDLE),
    .load(carga),
    .valor(estado == ACENDE ? CARGA_OFF : CARGA_ON),
    .contagem(contagem),
    .fim(tc)
  );
  // sequencing FSM with registered address, LEDs and end pulse
  always_ff @(posedge clock)
    if (reset) begin
      estado       <= IDLE;
      rodada_reg   <= '0;
      mem_endereco <= '0;
      leds         <= '0;
      pronto       <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        IDLE: if (iniciar) begin
          estado       <= ENDERECA;
          rodada_reg   <= rodada;
          mem_endereco <= '0;
          leds         <= '0;
        end
        ENDERECA: begin
          estado <= ACENDE;
          leds   <= mem_dado;
        end
        ACENDE: if (tc) begin
          estado <= APAGA;
          leds   <= '0;
        end
        APAGA: if (tc) begin
          if (ultimo) begin
`ifdef EXIBE_PISCA_FIM_EN
            estado <= PISCA;
            leds   <= '1;
`else
            estado <= FIM;
            pronto <= 1'b1;
`endif
          end else begin
            estado       <= ENDERECA;
            mem_endereco <= mem_endereco + 1'b1;
          end
        end
`ifdef EXIBE_PISCA_FIM_EN
        PISCA: if (tc) begin
          estado <= FIM;
          leds   <= '0;
          pronto <= 1'b1;
        end
`endif
        FIM: estado <= IDLE;
        default: estado <= IDLE;
      endcase
    end
  logic unused_contagem;
  assign unused_contagem = ^contagem;
endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Sequence-display engine for the memory game (Genius-style) datapath: the output side of the button/LED interface.
- On a start pulse it reads the stored play sequence from the jogadas ROM, addresses 0..rodada.
- It lights each stored 4-bit play on the LEDs for a fixed time, then blanks them for a fixed gap.
- It pulses pronto when the round has been shown; the game FSM then hands control to the button-input path.

Parameters:
- ON_CYCLES, 500: clock cycles each play is held on leds (>=1).
- OFF_CYCLES, 250: clock cycles leds are dark between plays (>=1).
- ADDR_W, 4: ROM address / rodada width.
- DATA_W, 4: play width; one-hot, one bit per button/LED.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- iniciar  in  1  start request; sampled only in IDLE.
- rodada  in  ADDR_W  index of last play to show; captured when iniciar is accepted.
- mem_dado  in  DATA_W  ROM read data; synchronous ROM, valid 1 cycle after mem_endereco changes.
- mem_endereco  out  ADDR_W  ROM address, registered.
- leds  out  DATA_W  LED drive, registered.
- ocupado  out  1  high whenever state != IDLE.
- pronto  out  1  one-cycle pulse at end of sequence.
- db_estado  out  4  state encoding, for the 7-segment debug display.

Behaviour:
- Reset values: mem_endereco=0, leds=0, ocupado=0, pronto=0, db_estado=IDLE (0x0). State=IDLE, rodada_reg=0, timer=0.
- Reset mid-sequence aborts immediately. There is no pronto pulse, and leds go to 0 on the next edge.
- States and encodings: IDLE=0x0, ENDERECA=0x1, ACENDE=0x2, APAGA=0x3, FIM=0xF.
- IDLE, iniciar=1 → ENDERECA. Capture rodada_reg=rodada, set mem_endereco=0, leds=0.
- ENDERECA: single wait cycle for ROM latency → ACENDE. On this edge leds<=mem_dado and timer<=0.
- ACENDE: leds hold; timer increments. When timer==ON_CYCLES-1 → APAGA, with leds<=0 and timer<=0.
- APAGA: timer increments. When timer==OFF_CYCLES-1:
  - if mem_endereco==rodada_reg → FIM;
  - else mem_endereco<=mem_endereco+1 → ENDERECA.
- FIM: pronto=1 for exactly this cycle → IDLE.
- Timing: per play = 1+ON_CYCLES+OFF_CYCLES cycles. Edge of accepted iniciar to pronto high = 1 + (rodada+1)(1+ON_CYCLES+OFF_CYCLES) cycles.
- iniciar while not IDLE is ignored. A held iniciar does not retrigger until FIM→IDLE has occurred, and restarts on the first IDLE cycle if still high.
- rodada changes after capture have no effect.
- rodada=0 shows one play. rodada=2^ADDR_W-1 shows all 16 plays. mem_endereco never wraps: the compare precedes the increment.
- mem_dado is passed through unchecked. Non-one-hot values are displayed as-is.
- Timer width: clog2(max(ON_CYCLES,OFF_CYCLES)+1).

Optional Feature:
- Macro EXIBE_PISCA_FIM_EN.
- Defined: extra state PISCA=0x4 between the last APAGA and FIM. leds={DATA_W{1'b1}} for ON_CYCLES cycles, then FIM. pronto is delayed by ON_CYCLES cycles.
- Undefined: the PISCA state and its logic are absent; timing is exactly as above.

Decomposition:
- Shared package jogo_pkg: state encodings (IDLE/ENDERECA/ACENDE/APAGA/PISCA/FIM as 4-bit localparams), plus default ON/OFF cycle constants.
- One natural sub-module: contador_tempo (loadable up-counter with clear and terminal-count flag at parameter LIMITE), instantiated once and reloaded per phase.

Test Plan:
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2. ROM contents 0001,0010,0100,1000,0100,...
- Reset check: reset=1 for 1 cycle → all outputs 0, db_estado=0x0. iniciar low for 10 cycles → no change.
- rodada=0, iniciar pulse: leds=0001 for 4 cycles, then 0 for 2; pronto pulses exactly 8 cycles after iniciar edge; ocupado high throughout.
- rodada=3: leds sequence 0001,0010,0100,1000, each 4 on / 2 off; mem_endereco steps 0→3; pronto after 1+4·7=29 cycles.
- rodada=15: 16 plays shown, mem_endereco ends at 15 with no wrap to 0; pronto after 113 cycles.
- iniciar re-pulsed mid-sequence and rodada changed to 1 during run → ignored; the run completes per the original rodada=3.
- reset asserted during ACENDE → next cycle leds=0, IDLE, no pronto. With EXIBE_PISCA_FIM_EN, rodada=0 → leds=1111 for 4 cycles after the gap, and pronto at cycle 12.
